// File: rtl/display_multiplexado.sv
// Time-multiplexed driver for common-anode 7-segment digits.
// Latches a hex value and scans one digit per refresh slot, with decimal point, blank mask and leading-zero suppression.
module display_multiplexado #(
    parameter int unsigned N_DIGITOS         = 4,
    parameter int unsigned DIV_REFRESH       = 50000,
    parameter int unsigned ANODO_ATIVO_BAIXO = 1,
    localparam int unsigned IW = (N_DIGITOS > 1) ? $clog2(N_DIGITOS) : 1
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   carregar,
    input  logic [4*N_DIGITOS-1:0] valor,
    input  logic [N_DIGITOS-1:0]   pontos,
    input  logic [N_DIGITOS-1:0]   apagar,
    input  logic                   supressao_zeros,
    output logic [6:0]             segmentos,
    output logic                   ponto,
    output logic [N_DIGITOS-1:0]   anodos,
    output logic [IW-1:0]          digito_atual
);

    localparam int unsigned PW = (DIV_REFRESH > 1) ? $clog2(DIV_REFRESH) : 1;
    localparam int unsigned VW = 4 * N_DIGITOS;
    localparam logic [N_DIGITOS-1:0] ANODOS_OFF =
        (ANODO_ATIVO_BAIXO != 0) ? {N_DIGITOS{1'b1}} : {N_DIGITOS{1'b0}};

    logic [VW-1:0]        valor_r;
    logic [N_DIGITOS-1:0] pontos_r;
    logic [N_DIGITOS-1:0] apagar_r;
    logic [PW-1:0]        prescaler;

    logic [3:0]           nibble;
    logic                 ponto_sel;
    logic                 apagar_sel;
    logic                 suprimir_sel;
    logic                 zeros_acima;
    logic [N_DIGITOS-1:0] sel;
    logic [6:0]           segmentos_c;
    logic                 ponto_c;
    logic [N_DIGITOS-1:0] anodos_c;

    function automatic logic [6:0] decodifica(input logic [3:0] n);
        logic [6:0] s;
        case (n)
            4'h0: s = 7'b0000001;
            4'h1: s = 7'b1001111;
            4'h2: s = 7'b0010010;
            4'h3: s = 7'b0000110;
            4'h4: s = 7'b1001100;
            4'h5: s = 7'b0100100;
            4'h6: s = 7'b0100000;
            4'h7: s = 7'b0001111;
            4'h8: s = 7'b0000000;
            4'h9: s = 7'b0000100;
            4'hA: s = 7'b0001000;
            4'hB: s = 7'b1100000;
            4'hC: s = 7'b0110001;
            4'hD: s = 7'b1000010;
            4'hE: s = 7'b0110000;
            default: s = 7'b0111000;
        endcase
        return s;
    endfunction

    // Shadow copy of the display contents, reloaded on the load strobe
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            valor_r  <= '0;
            pontos_r <= '0;
            apagar_r <= '0;
        end else if (carregar) begin
            valor_r  <= valor;
            pontos_r <= pontos;
            apagar_r <= apagar;
        end
    end

    // Refresh prescaler and digit scan index
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            prescaler    <= '0;
            digito_atual <= '0;
        end else if (prescaler == PW'(DIV_REFRESH - 1)) begin
            prescaler    <= '0;
            digito_atual <= (digito_atual == IW'(N_DIGITOS - 1)) ? '0 : digito_atual + 1'b1;
        end else begin
            prescaler <= prescaler + 1'b1;
        end
    end

    // Select the current digit; zeros_acima tracks "all nibbles from k upward are zero"
    always_comb begin
        nibble       = '0;
        ponto_sel    = 1'b0;
        apagar_sel   = 1'b0;
        suprimir_sel = 1'b0;
        zeros_acima  = 1'b1;
        sel          = '0;
        for (int k = int'(N_DIGITOS) - 1; k >= 0; k--) begin
            zeros_acima = zeros_acima && (valor_r[4*k +: 4] == 4'h0);
            if (IW'(k) == digito_atual) begin
                nibble       = valor_r[4*k +: 4];
                ponto_sel    = pontos_r[k];
                apagar_sel   = apagar_r[k];
                suprimir_sel = zeros_acima && (k > 0);
                sel[k]       = 1'b1;
            end
        end
    end

    always_comb begin
        segmentos_c = 7'b1111111;
        ponto_c     = 1'b1;
        anodos_c    = ANODOS_OFF;
        if (!(apagar_sel || (supressao_zeros && suprimir_sel))) begin
            segmentos_c = decodifica(nibble);
            ponto_c     = ~ponto_sel;
            anodos_c    = (ANODO_ATIVO_BAIXO != 0) ? ~sel : sel;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            segmentos <= 7'b1111111;
            ponto     <= 1'b1;
            anodos    <= ANODOS_OFF;
        end else begin
            segmentos <= segmentos_c;
            ponto     <= ponto_c;
            anodos    <= anodos_c;
        end
    end

endmodule

// File: tb/tb_display_multiplexado.sv
// Directed bench for display_multiplexado: 4-digit scan at DIV_REFRESH=4 plus a 1-digit, DIV_REFRESH=1 instance.
module tb_display_multiplexado;

    logic        clock;
    logic        reset;
    logic        carregar;
    logic [15:0] valor;
    logic [3:0]  pontos;
    logic [3:0]  apagar;
    logic        supressao_zeros;
    logic [6:0]  segmentos;
    logic        ponto;
    logic [3:0]  anodos;
    logic [1:0]  digito_atual;

    logic        carregar1;
    logic [3:0]  valor1;
    logic [0:0]  pontos1;
    logic [0:0]  apagar1;
    logic        supr1;
    logic [6:0]  segmentos1;
    logic        ponto1;
    logic [0:0]  anodos1;
    logic [0:0]  digito1;

    int n;
    int n_verif;
    int n_falhas;
    logic [6:0] tab [16];

    display_multiplexado #(.N_DIGITOS(4), .DIV_REFRESH(4), .ANODO_ATIVO_BAIXO(1)) u_dut (
        .clock(clock), .reset(reset), .carregar(carregar), .valor(valor),
        .pontos(pontos), .apagar(apagar), .supressao_zeros(supressao_zeros),
        .segmentos(segmentos), .ponto(ponto), .anodos(anodos), .digito_atual(digito_atual)
    );

    display_multiplexado #(.N_DIGITOS(1), .DIV_REFRESH(1), .ANODO_ATIVO_BAIXO(1)) u_dut1 (
        .clock(clock), .reset(reset), .carregar(carregar1), .valor(valor1),
        .pontos(pontos1), .apagar(apagar1), .supressao_zeros(supr1),
        .segmentos(segmentos1), .ponto(ponto1), .anodos(anodos1), .digito_atual(digito1)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    task automatic verifica(input string tag, input logic [31:0] obs, input logic [31:0] esp);
        n_verif++;
        if (obs !== esp) begin
            n_falhas++;
            $display("FAIL %s: obtido %0h esperado %0h (t=%0t)", tag, obs, esp, $time);
        end
    endtask

    task automatic ciclo();
        @(posedge clock);
        #1;
        n++;
    endtask

    task automatic carrega(input logic [15:0] v, input logic [3:0] p, input logic [3:0] a);
        valor    = v;
        pontos   = p;
        apagar   = a;
        carregar = 1'b1;
        ciclo();
        carregar = 1'b0;
    endtask

    // 16 cycles; segs/anos/pts are packed {digit3,...,digit0}
    task automatic varre(input string tag, input logic [27:0] segs, input logic [15:0] anos,
                         input logic [3:0] pts);
        int d;
        for (int c = 0; c < 16; c++) begin
            ciclo();
            d = ((n - 1) / 4) % 4;
            verifica({tag, " anodos"}, 32'(anodos), 32'(anos[4*d +: 4]));
            verifica({tag, " segmentos"}, 32'(segmentos), 32'(segs[7*d +: 7]));
            verifica({tag, " ponto"}, 32'(ponto), 32'(pts[d]));
            verifica({tag, " digito_atual"}, 32'(digito_atual), 32'((n / 4) % 4));
        end
    endtask

    task automatic verifica_reset(input string tag);
        verifica({tag, " anodos"}, 32'(anodos), 32'hF);
        verifica({tag, " segmentos"}, 32'(segmentos), 32'h7F);
        verifica({tag, " ponto"}, 32'(ponto), 32'h1);
        verifica({tag, " digito_atual"}, 32'(digito_atual), 32'h0);
    endtask

    initial begin
        tab = '{7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
                7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
                7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
                7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000};
        n = 0; n_verif = 0; n_falhas = 0;
        reset = 1'b0; carregar = 1'b0; valor = '0; pontos = '0; apagar = '0;
        supressao_zeros = 1'b0;
        carregar1 = 1'b1; valor1 = '0; pontos1 = 1'b1; apagar1 = 1'b0; supr1 = 1'b1;

        #1 reset = 1'b1;
        #2 verifica_reset("reset inicial");
        @(posedge clock); #1;
        reset = 1'b0;
        n = 0;

        // First edge after reset: digit 0 lit showing 0 from the cleared shadow
        ciclo();
        verifica("primeiro anodos", 32'(anodos), 32'hE);
        verifica("primeiro segmentos", 32'(segmentos), 32'(7'b0000001));
        verifica("primeiro ponto", 32'(ponto), 32'h1);

        // Reset asserted mid-cycle while digit 2 is being scanned
        for (int k = 0; k < 40 && digito_atual != 2'd2; k++) ciclo();
        verifica("chegou digito 2", 32'(digito_atual), 32'h2);
        #2 reset = 1'b1;
        #1 verifica_reset("reset meio varredura");
        @(posedge clock); #1;
        reset = 1'b0;
        n = 0;

        carrega(16'h12AF, 4'b0000, 4'b0000);
        varre("12AF", {7'b1001111, 7'b0010010, 7'b0001000, 7'b0111000},
              16'b0111_1011_1101_1110, 4'b1111);

        supressao_zeros = 1'b1;
        carrega(16'h0030, 4'b0000, 4'b0000);
        varre("sup 0030", {7'b1111111, 7'b1111111, 7'b0000110, 7'b0000001},
              16'b1111_1111_1101_1110, 4'b1111);
        carrega(16'h0000, 4'b0000, 4'b0000);
        varre("sup 0000", {7'b1111111, 7'b1111111, 7'b1111111, 7'b0000001},
              16'b1111_1111_1111_1110, 4'b1111);

        supressao_zeros = 1'b0;
        carrega(16'h8888, 4'b0100, 4'b0001);
        varre("pontos apagar", {7'b0000000, 7'b0000000, 7'b0000000, 7'b1111111},
              16'b0111_1011_1101_1111, 4'b1011);

        // Load in the middle of digit 1's slot: new nibble one edge later
        for (int k = 0; k < 16 && (n % 16) != 5; k++) ciclo();
        valor    = 16'h8878;
        carregar = 1'b1;
        ciclo();
        carregar = 1'b0;
        verifica("carga d1 antes anodos", 32'(anodos), 32'hD);
        verifica("carga d1 antes segmentos", 32'(segmentos), 32'(7'b0000000));
        ciclo();
        verifica("carga d1 depois anodos", 32'(anodos), 32'hD);
        verifica("carga d1 depois segmentos", 32'(segmentos), 32'(7'b0001111));

        // Single digit, advance every cycle: all 16 codes
        for (int v = 0; v < 16; v++) begin
            valor1 = 4'(v);
            ciclo();
            ciclo();
            verifica($sformatf("n1 segmentos %0h", v), 32'(segmentos1), 32'(tab[v]));
            verifica($sformatf("n1 anodos %0h", v), 32'(anodos1), 32'h0);
            verifica($sformatf("n1 digito %0h", v), 32'(digito1), 32'h0);
            verifica($sformatf("n1 ponto %0h", v), 32'(ponto1), 32'h0);
        end
        apagar1 = 1'b1;
        ciclo();
        ciclo();
        verifica("n1 apagado segmentos", 32'(segmentos1), 32'h7F);
        verifica("n1 apagado anodos", 32'(anodos1), 32'h1);
        verifica("n1 apagado ponto", 32'(ponto1), 32'h1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_verif, n_falhas);
        $finish;
    end

endmodule
